rev_buf: RTL and testbench
==========================

REV_BUF -- requirements
Module: rev_buf

Interface
REQ-001 SHALL have parameter DEPTH, default viterbi_pkg::TB_DEPTH (8), giving the decoded bits per traceback block; DEPTH SHALL be a power of two and at least 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port wr_en, input, 1 bit: a decoded bit is present on d_in this cycle; driven by the traceback unit's wr_en.
REQ-005 SHALL have port d_in, input, 1 bit: decoded bit in reverse time order, driven by the traceback unit's d_o.
REQ-006 SHALL have port d_out, output, 1 bit: decoded bit in forward time order.
REQ-007 SHALL have port valid_o, output, 1 bit: d_out is meaningful this cycle.
REQ-008 SHALL have port last_o, output, 1 bit: d_out is the final bit of a block; asserted only with valid_o.
REQ-009 SHALL have port fill_o, output, clog2(DEPTH)+1 bits: number of bits in the current write bank.

Function
REQ-010 SHALL hold two DEPTH-bit banks (ping-pong); wsel selects the write bank, and the other bank is the read bank.
REQ-011 On each rising edge with wr_en=1, SHALL store d_in at bank[wsel][wptr] and increment wptr; wr_en=0 SHALL hold wptr and bank contents.
REQ-012 On the edge that writes index DEPTH-1, SHALL: toggle wsel, reset wptr to 0, set rd_active=1, and load rptr=DEPTH-1.
REQ-013 While rd_active=1, each edge SHALL register d_out=bank[~wsel][rptr] and valid_o=1, then decrement rptr; last_o=1 SHALL accompany rptr=0, and that edge SHALL clear rd_active.
REQ-014 Latency: the first output bit SHALL be visible the cycle after the edge that wrote the last bit of the block; valid_o SHALL then stay high for exactly DEPTH consecutive cycles.
REQ-015 Output order: the output bits SHALL be the last-written bit first, so the block emerges in the reverse of input order.
REQ-016 If the edge that completes a new write bank coincides with the edge emitting last_o, the next block SHALL start draining on the following cycle with no gap: valid_o continuous, rptr reloaded to DEPTH-1.
REQ-017 If a new block completes while rd_active=1 and rptr!=0 (overrun, impossible under continuous traceback), SHALL abandon the old drain and start the new block per REQ-012.
REQ-018 When valid_o=0, d_out and last_o SHALL be driven 0.
REQ-019 Partial blocks (wr_en stopping before DEPTH bits) SHALL remain buffered, with no output, until the block completes.
REQ-020 fill_o SHALL equal wptr and read 0 on the cycle after a swap.

Reset
REQ-021 rst=0 SHALL asynchronously force wptr=0, rptr=DEPTH-1, wsel=0, rd_active=0, d_out=0, valid_o=0, last_o=0, fill_o=0.
REQ-022 Bank contents SHALL be non-reset storage; no output SHALL depend on bank contents until after a post-reset block completes.
REQ-023 Reset asserted mid-drain or mid-fill SHALL discard all buffered bits; the first post-reset output SHALL be a complete fresh block.

Structure
REQ-024 TB_DEPTH and the shared state-width constant SHALL live in viterbi_pkg, which the traceback unit also imports.
REQ-025 The block SHALL be a single module with no sub-modules; each bank SHALL be a DEPTH-bit register vector.

Verification
REQ-026 Reset then 8 writes d_in=1,0,1,1,0,0,1,0 -> valid_o high for 8 cycles starting 1 cycle after the 8th write, d_out=0,1,0,0,1,1,0,1, last_o on the 8th output bit only.
REQ-027 16 back-to-back writes (two blocks) -> 16 contiguous valid_o cycles, each block reversed, last_o at output bits 8 and 16.
REQ-028 5 writes, 10 idle cycles, 3 writes -> no valid_o until the 8th write, then the correct reversed 8-bit block; fill_o sequence 1..5, holds 5, 6,7,0.
REQ-029 rst pulsed low after 4 output bits of a drain -> valid_o=0 immediately (asynchronous); no stale bits afterward; the next 8 writes produce a correct block.
REQ-030 Random wr_en at 50% over 1000 blocks against a scoreboard model -> zero mismatches, and valid_o never asserted without a completed block.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared constants for the Viterbi decoder datapath: traceback block length
// and trellis state width, imported by the traceback unit and the reversal buffer.
package viterbi_pkg;

   localparam int TB_DEPTH = 8;
   localparam int STATE_W  = 6;

endpackage

// File: rtl/rev_buf.sv
// Ping-pong reversal buffer: collects a traceback block (newest bit first)
// in one bank while the other bank drains in forward time order.
module rev_buf
   import viterbi_pkg::*;
#(
   parameter int DEPTH = TB_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic                     d_in,
   output logic                     d_out,
   output logic                     valid_o,
   output logic                     last_o,
   output logic [$clog2(DEPTH):0]   fill_o
);

   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0] bank0;
   logic [DEPTH-1:0] bank1;
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             wsel;
   logic             rd_active;
   logic             blk_done;
   logic             rd_bit;

   assign blk_done = wr_en && (wptr == AW'(DEPTH - 1));
   assign rd_bit   = wsel ? bank0[rptr] : bank1[rptr];
   assign fill_o   = {1'b0, wptr};

   // Bank storage carries no reset; rd_active gates every read of it.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         if (wsel) bank1[wptr] <= d_in;
         else      bank0[wptr] <= d_in;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr      <= '0;
         rptr      <= AW'(DEPTH - 1);
         wsel      <= 1'b0;
         rd_active <= 1'b0;
         d_out     <= 1'b0;
         valid_o   <= 1'b0;
         last_o    <= 1'b0;
      end else begin
         if (blk_done) begin
            wsel <= ~wsel;
            wptr <= '0;
         end else if (wr_en) begin
            wptr <= wptr + 1'b1;
         end

         if (rd_active) begin
            d_out   <= rd_bit;
            valid_o <= 1'b1;
            last_o  <= (rptr == '0);
            rptr    <= rptr - 1'b1;
            if (rptr == '0) rd_active <= 1'b0;
         end else begin
            d_out   <= 1'b0;
            valid_o <= 1'b0;
            last_o  <= 1'b0;
         end

         // A freshly completed block always wins, whether the old drain
         // just finished or is being abandoned.
         if (blk_done) begin
            rd_active <= 1'b1;
            rptr      <= AW'(DEPTH - 1);
         end
      end
   end

endmodule

// File: tb/tb_rev_buf.sv
// Bench for rev_buf: hand-computed vector tables, directed corner sequences
// and a long random run against a queue-based reference model.
module tb_rev_buf;
   import viterbi_pkg::*;

   localparam int D = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en;
   logic       d_in;
   logic       d_out;
   logic       valid_o;
   logic       last_o;
   logic [3:0] fill_o;

   always #5 clk = ~clk;

   rev_buf #(.DEPTH(D)) dut (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .d_in    (d_in),
      .d_out   (d_out),
      .valid_o (valid_o),
      .last_o  (last_o),
      .fill_o  (fill_o)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic       wr;
      logic       d;
      logic       v;
      logic       dout;
      logic       last;
      logic [3:0] fill;
   } vec_t;
   vec_t vecs[$];

   typedef struct {
      bit d;
      bit last;
   } ob_t;
   ob_t mq[$];
   bit  mblk[D];
   int  mcnt = 0;
   bit  ev, ed, el;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 30)
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      mcnt = 0;
   endtask

   task automatic model_edge(input bit wr, input bit d);
      ob_t o;
      if (mq.size() > 0) begin
         o  = mq.pop_front();
         ev = 1'b1;
         ed = o.d;
         el = o.last;
      end else begin
         ev = 1'b0;
         ed = 1'b0;
         el = 1'b0;
      end
      if (wr) begin
         mblk[mcnt] = d;
         mcnt++;
         if (mcnt == D) begin
            mq.delete();
            for (int i = D - 1; i >= 0; i--) mq.push_back('{d: mblk[i], last: (i == 0)});
            mcnt = 0;
         end
      end
   endtask

   task automatic cyc(input bit wr, input bit d);
      wr_en = wr;
      d_in  = d;
      @(posedge clk);
      #1;
      model_edge(wr, d);
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_valid"}, 32'(valid_o), 32'(ev));
      chk({tag, "_dout"},  32'(d_out),   32'(ed));
      chk({tag, "_last"},  32'(last_o),  32'(el));
      chk({tag, "_fill"},  32'(fill_o),  32'(mcnt));
   endtask

   task automatic add(input logic wr, input logic d, input logic v, input logic dout,
                      input logic last, input logic [3:0] fill);
      vec_t x;
      x.wr = wr; x.d = d; x.v = v; x.dout = dout; x.last = last; x.fill = fill;
      vecs.push_back(x);
   endtask

   initial begin
      bit blk26[D];
      bit blk28[8];
      logic [15:0] pat;
      int vcnt, run, maxrun, lastmask, nw, pos;
      bit  w;

      blk26 = '{1, 0, 1, 1, 0, 0, 1, 0};
      blk28 = '{1, 1, 0, 1, 0, 1, 0, 0};

      // Single block 1,0,1,1,0,0,1,0 -> drains as 0,1,0,0,1,1,0,1.
      for (int i = 0; i < D; i++) add(1, blk26[i], 0, 0, 0, 4'((i + 1) % D));
      add(0, 0, 1, 0, 0, 0); add(0, 0, 1, 1, 0, 0); add(0, 0, 1, 0, 0, 0); add(0, 0, 1, 0, 0, 0);
      add(0, 0, 1, 1, 0, 0); add(0, 0, 1, 1, 0, 0); add(0, 0, 1, 0, 0, 0); add(0, 0, 1, 1, 1, 0);
      add(0, 0, 0, 0, 0, 0);
      // Partial block: 5 writes, 10 idle, 3 writes; block 11010100 drains as 00101011.
      for (int i = 0; i < 5; i++)  add(1, blk28[i], 0, 0, 0, 4'(i + 1));
      for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 0, 5);
      add(1, blk28[5], 0, 0, 0, 6); add(1, blk28[6], 0, 0, 0, 7); add(1, blk28[7], 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0); add(0, 0, 1, 0, 0, 0); add(0, 0, 1, 1, 0, 0); add(0, 0, 1, 0, 0, 0);
      add(0, 0, 1, 1, 0, 0); add(0, 0, 1, 0, 0, 0); add(0, 0, 1, 1, 0, 0); add(0, 0, 1, 1, 1, 0);
      add(0, 0, 0, 0, 0, 0);

      rst   = 1'b0;
      wr_en = 1'b0;
      d_in  = 1'b0;
      #22;
      chk("rst_valid", 32'(valid_o), 0);
      chk("rst_dout",  32'(d_out),   0);
      chk("rst_last",  32'(last_o),  0);
      chk("rst_fill",  32'(fill_o),  0);
      rst = 1'b1;

      foreach (vecs[k]) begin
         cyc(vecs[k].wr, vecs[k].d);
         chk($sformatf("vec%0d_valid", k), 32'(valid_o), 32'(vecs[k].v));
         chk($sformatf("vec%0d_dout", k),  32'(d_out),   32'(vecs[k].dout));
         chk($sformatf("vec%0d_last", k),  32'(last_o),  32'(vecs[k].last));
         chk($sformatf("vec%0d_fill", k),  32'(fill_o),  32'(vecs[k].fill));
      end

      // Two back-to-back blocks must drain as one unbroken 16-cycle run.
      pat = 16'hA5C3;
      vcnt = 0; run = 0; maxrun = 0; lastmask = 0;
      for (int i = 0; i < 26; i++) begin
         if (i < 16) cyc(1, pat[i]);
         else        cyc(0, 0);
         chk_model("b2b");
         if (valid_o === 1'b1) begin
            vcnt++;
            run++;
            if (run > maxrun) maxrun = run;
            if (last_o === 1'b1) lastmask |= (1 << vcnt);
         end else begin
            run = 0;
         end
      end
      chk("b2b_vcount", 32'(vcnt), 16);
      chk("b2b_run",    32'(maxrun), 16);
      chk("b2b_lastpos", 32'(lastmask), 32'((1 << 8) | (1 << 16)));

      // Asynchronous reset four bits into a drain.
      for (int i = 0; i < D; i++) cyc(1, 1'(i % 3 == 0));
      for (int i = 0; i < 4; i++) begin cyc(0, 0); chk_model("predrain"); end
      #2 rst = 1'b0;
      #1;
      chk("arst_valid", 32'(valid_o), 0);
      chk("arst_dout",  32'(d_out),   0);
      chk("arst_last",  32'(last_o),  0);
      chk("arst_fill",  32'(fill_o),  0);
      model_reset();
      #3 rst = 1'b1;
      vcnt = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(0, 0);
         chk_model("post_rst");
         if (valid_o !== 1'b0) vcnt++;
      end
      chk("stale_bits", 32'(vcnt), 0);
      for (int i = 0; i < 3; i++) cyc(1, 1);
      chk_model("midfill");
      #2 rst = 1'b0;
      model_reset();
      #3 rst = 1'b1;
      for (int i = 0; i < D + 9; i++) begin
         if (i < D) cyc(1, 1'(i == 1 || i == 2 || i == 6));
         else       cyc(0, 0);
         chk_model("fresh");
      end

      // Long random run at 50% write density.
      nw = 0;
      while (nw < 1000 * D) begin
         w = 1'($urandom_range(0, 1));
         cyc(w, 1'($urandom_range(0, 1)));
         if (w) nw++;
         chk_model("rand");
      end
      for (int i = 0; i < D + 2; i++) begin
         cyc(0, 0);
         chk_model("rand_tail");
      end
      pos = mq.size();
      chk("rand_drained", 32'(pos), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
